reaction_timer: RTL and testbench

Measures player reaction time for the F1 lights game: it watches the light vector driven by the lights state machine, starts timing on lights-out and stops on the player's button press. It reports the result in ticks (nominally milliseconds), flags jump starts (press while lights are lit) and holds the result until cleared. It sits downstream of the lights sequencer, consuming its `data_out` as `lights_in`.

---
 rtl/reaction_timer_pkg.sv | 17 +
 rtl/reaction_timer_if.sv | 24 ++
 rtl/reaction_timer_tick_gen.sv | 27 ++
 rtl/reaction_timer.sv | 122 ++++++++++++
 tb/tb_reaction_timer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and helpers for the F1 reaction timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    FOUL   = 3'd4
  } reaction_state_t;

  // All-ones value of a counter of the given width.
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Player-facing bus of the reaction timer: light/button/clear in, results out.
interface reaction_timer_if #(
  parameter int unsigned LIGHT_WIDTH = 8,
  parameter int unsigned TIME_WIDTH  = 10
);
  logic [LIGHT_WIDTH-1:0] lights_in;
  logic                   button;
  logic                   clear;
  logic [TIME_WIDTH-1:0]  time_ms;
  logic                   valid;
  logic                   jump_start;
  logic                   overflow;
  logic [TIME_WIDTH-1:0]  best_ms;

  modport master (
    output lights_in, button, clear,
    input  time_ms, valid, jump_start, overflow, best_ms
  );

  modport slave (
    input  lights_in, button, clear,
    output time_ms, valid, jump_start, overflow, best_ms
  );
endinterface

// File: rtl/reaction_timer_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles, restartable.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);
  localparam int unsigned    PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  assign tick = en && !restart && (cnt_q == LAST);
endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: times lights-out to button press, flags jump starts.
// Optional best-time tracking enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int unsigned LIGHT_WIDTH = 8,
  parameter int unsigned TIME_WIDTH  = 10,
  parameter int unsigned TICK_DIV    = 1000
) (
  input logic             clk,
  input logic             rst,
  reaction_timer_if.slave bus
);
  localparam logic [TIME_WIDTH-1:0]  CNT_MAX    = TIME_WIDTH'(sat_max(TIME_WIDTH));
  localparam logic [LIGHT_WIDTH-1:0] LIGHTS_OFF = '0;

  reaction_state_t        state_q;
  logic                   button_q;
  logic [TIME_WIDTH-1:0]  cnt_q;
  logic [TIME_WIDTH-1:0]  time_q;
  logic                   valid_q;
  logic                   jump_q;
  logic                   ovf_q;

  logic                   rise_c;
  logic                   lights_on_c;
  logic                   tick_c;
  logic                   hit_max_c;
  logic                   done_evt_c;
  logic [TIME_WIDTH-1:0]  cnt_next_c;

  always_comb begin
    rise_c      = bus.button & ~button_q;
    lights_on_c = (bus.lights_in != LIGHTS_OFF);
    done_evt_c  = (state_q == TIMING) && rise_c && !bus.clear;
    cnt_next_c  = cnt_q;
    hit_max_c   = 1'b0;
    // Saturating increment; flag the cycle that lands on the ceiling.
    if (tick_c && (cnt_q != CNT_MAX)) begin
      cnt_next_c = cnt_q + TIME_WIDTH'(1);
      hit_max_c  = (cnt_next_c == CNT_MAX);
    end
  end

  // Prescaler sits at zero outside TIMING, so lights-out always starts a full period.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (state_q != TIMING),
    .en      (state_q == TIMING),
    .tick    (tick_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      button_q <= 1'b0;
      cnt_q    <= '0;
      time_q   <= '0;
      valid_q  <= 1'b0;
      jump_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      button_q <= bus.button;
      if (bus.clear) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        jump_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (lights_on_c) state_q <= ARMED;
          end
          ARMED: begin
            if (rise_c) begin
              state_q <= FOUL;
              jump_q  <= 1'b1;
            end else if (!lights_on_c) begin
              state_q <= TIMING;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
            end
          end
          TIMING: begin
            cnt_q <= cnt_next_c;
            if (hit_max_c) ovf_q <= 1'b1;
            if (rise_c) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              time_q  <= cnt_next_c;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.time_ms    = time_q;
  assign bus.valid      = valid_q;
  assign bus.jump_start = jump_q;
  assign bus.overflow   = ovf_q;

`ifdef REACTION_BEST_TIME_EN
  logic [TIME_WIDTH-1:0] best_q;

  // Only clean runs compete; a run saturating on the press cycle is excluded too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q <= CNT_MAX;
    end else if (done_evt_c && !ovf_q && !hit_max_c && (cnt_next_c < best_q)) begin
      best_q <= cnt_next_c;
    end
  end

  assign bus.best_ms = best_q;
`else
  assign bus.best_ms = CNT_MAX;
`endif
endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: main instance (TICK_DIV=4, TIME_WIDTH=10)
// plus a narrow instance (TICK_DIV=2, TIME_WIDTH=4) for saturation.
module tb_reaction_timer;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [9:0] best_m;

  reaction_timer_if #(.LIGHT_WIDTH(8), .TIME_WIDTH(10)) bus_a ();
  reaction_timer_if #(.LIGHT_WIDTH(8), .TIME_WIDTH(4))  bus_b ();

  reaction_timer #(.LIGHT_WIDTH(8), .TIME_WIDTH(10), .TICK_DIV(4)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reaction_timer #(.LIGHT_WIDTH(8), .TIME_WIDTH(4), .TICK_DIV(2)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic note_best(input logic [9:0] t, input logic ovf);
`ifdef REACTION_BEST_TIME_EN
    if (!ovf && t < best_m) best_m = t;
`endif
  endtask

  // One full run on instance A: press lands n*4+r cycles after TIMING entry.
  task automatic do_run(input int n, input int r, input logic [9:0] exp_t, input logic exp_ovf);
    bus_a.button    = 1'b0;
    bus_a.lights_in = 8'h01;
    step();
    bus_a.lights_in = 8'h00;
    step();
    repeat (n * 4 + r - 1) step();
    bus_a.button = 1'b1;
    step();
    note_best(exp_t, exp_ovf);
    chk("run_time", 32'(bus_a.time_ms), 32'(exp_t));
    chk("run_valid", 32'(bus_a.valid), 32'd1);
    chk("run_ovf", 32'(bus_a.overflow), 32'(exp_ovf));
    chk("run_best", 32'(bus_a.best_ms), 32'(best_m));
    bus_a.button = 1'b0;
    bus_a.clear  = 1'b1;
    step();
    bus_a.clear = 1'b0;
    chk("run_clr_valid", 32'(bus_a.valid), 32'd0);
    chk("run_clr_ovf", 32'(bus_a.overflow), 32'd0);
    chk("run_clr_time", 32'(bus_a.time_ms), 32'(exp_t));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    best_m = 10'h3FF;
    rst    = 1'b0;
    bus_a.lights_in = 8'h00; bus_a.button = 1'b0; bus_a.clear = 1'b0;
    bus_b.lights_in = 8'h00; bus_b.button = 1'b0; bus_b.clear = 1'b0;
    #1;
    chk("rst_time", 32'(bus_a.time_ms), 32'd0);
    chk("rst_valid", 32'(bus_a.valid), 32'd0);
    chk("rst_jump", 32'(bus_a.jump_start), 32'd0);
    chk("rst_ovf", 32'(bus_a.overflow), 32'd0);
    chk("rst_best", 32'(bus_a.best_ms), 32'h3FF);
    chk("rst_best_b", 32'(bus_b.best_ms), 32'hF);
    step();
    step();
    rst = 1'b1;
    step();

    // Button rise in IDLE does nothing.
    bus_a.button = 1'b1;
    step();
    chk("idle_btn_valid", 32'(bus_a.valid), 32'd0);
    chk("idle_btn_jump", 32'(bus_a.jump_start), 32'd0);
    bus_a.button = 1'b0;
    step();

    // Normal run: press 41 cycles after lights-out -> 10 ticks.
    bus_a.lights_in = 8'h01; step();
    bus_a.lights_in = 8'hFF; step();
    bus_a.lights_in = 8'h00; step();
    repeat (40) step();
    chk("pre_press_valid", 32'(bus_a.valid), 32'd0);
    chk("pre_press_time", 32'(bus_a.time_ms), 32'd0);
    bus_a.button = 1'b1;
    #1;
    chk("no_comb_path", 32'(bus_a.valid), 32'd0);
    step();
    note_best(10'd10, 1'b0);
    chk("norm_time", 32'(bus_a.time_ms), 32'd10);
    chk("norm_valid", 32'(bus_a.valid), 32'd1);
    chk("norm_jump", 32'(bus_a.jump_start), 32'd0);
    chk("norm_ovf", 32'(bus_a.overflow), 32'd0);
    chk("norm_best", 32'(bus_a.best_ms), 32'(best_m));

    // Jump start.
    bus_a.button = 1'b0;
    bus_a.clear  = 1'b1;
    step();
    bus_a.clear = 1'b0;
    chk("clr_valid", 32'(bus_a.valid), 32'd0);
    chk("clr_keep_time", 32'(bus_a.time_ms), 32'd10);
    chk("clr_keep_best", 32'(bus_a.best_ms), 32'(best_m));
    bus_a.lights_in = 8'h0F;
    step();
    bus_a.button = 1'b1;
    step();
    chk("foul_jump", 32'(bus_a.jump_start), 32'd1);
    chk("foul_valid", 32'(bus_a.valid), 32'd0);
    chk("foul_time", 32'(bus_a.time_ms), 32'd10);
    bus_a.lights_in = 8'h00;
    bus_a.button    = 1'b0;
    bus_a.clear     = 1'b1;
    step();
    bus_a.clear = 1'b0;
    chk("foul_clr_jump", 32'(bus_a.jump_start), 32'd0);
    step();
    chk("foul_idle_jump", 32'(bus_a.jump_start), 32'd0);

    // Clear beats a simultaneous button rise in TIMING.
    bus_a.lights_in = 8'h01; step();
    bus_a.lights_in = 8'h00; step();
    repeat (9) step();
    bus_a.clear  = 1'b1;
    bus_a.button = 1'b1;
    step();
    bus_a.clear = 1'b0;
    chk("clrpri_valid", 32'(bus_a.valid), 32'd0);
    chk("clrpri_time", 32'(bus_a.time_ms), 32'd10);
    chk("clrpri_ovf", 32'(bus_a.overflow), 32'd0);
    step();
    chk("clrpri_idle_valid", 32'(bus_a.valid), 32'd0);
    bus_a.button = 1'b0;
    step();

    // Best-time sequence: 12, 7, 9 ticks and one saturated run.
    do_run(12, 2, 10'd12, 1'b0);
    do_run(7, 0, 10'd7, 1'b0);
    do_run(9, 3, 10'd9, 1'b0);
    do_run(1100, 0, 10'h3FF, 1'b1);
    chk("best_final", 32'(bus_a.best_ms), 32'(best_m));

    // Saturation on the narrow instance.
    bus_b.lights_in = 8'h01; step();
    bus_b.lights_in = 8'h00; step();
    repeat (29) step();
    chk("sat_ovf_before", 32'(bus_b.overflow), 32'd0);
    step();
    chk("sat_ovf_set", 32'(bus_b.overflow), 32'd1);
    repeat (10) step();
    chk("sat_no_valid", 32'(bus_b.valid), 32'd0);
    bus_b.button = 1'b1;
    step();
    chk("sat_time", 32'(bus_b.time_ms), 32'd15);
    chk("sat_ovf", 32'(bus_b.overflow), 32'd1);
    chk("sat_valid", 32'(bus_b.valid), 32'd1);
    chk("sat_best", 32'(bus_b.best_ms), 32'hF);

    // Asynchronous reset mid-clock with random inputs while results are held.
    do_run(5, 1, 10'd5, 1'b0);
    bus_a.lights_in = 8'($urandom);
    bus_a.button    = 1'($urandom);
    bus_b.lights_in = 8'($urandom);
    #4;
    rst = 1'b0;
    #1;
    chk("arst_time", 32'(bus_a.time_ms), 32'd0);
    chk("arst_valid_b", 32'(bus_b.valid), 32'd0);
    chk("arst_ovf_b", 32'(bus_b.overflow), 32'd0);
    chk("arst_time_b", 32'(bus_b.time_ms), 32'd0);
    chk("arst_jump", 32'(bus_a.jump_start), 32'd0);
    chk("arst_best", 32'(bus_a.best_ms), 32'h3FF);
    best_m = 10'h3FF;
    bus_a.lights_in = 8'h00; bus_a.button = 1'b0;
    bus_b.lights_in = 8'h00; bus_b.button = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("post_rst_valid", 32'(bus_a.valid), 32'd0);
    do_run(3, 0, 10'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
